// File: rtl/ks_pkg.sv
// ks_pkg: shared definitions for the multi-word Kogge-Stone add/subtract
// sequencer.
//   CHUNK_W  - width of one adder chunk (the 4-bit core width)
//   state_e  - controller FSM states
//   clog2()  - ceiling log2, used to size the chunk counter
package ks_pkg;

  localparam int CHUNK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2 with a floor of 1, so a counter is always at least one bit wide.
  function automatic int clog2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ks_multiword_add_ctrl_core.sv
// kogge_stone_4bit: purely combinational 4-bit Kogge-Stone adder.
// Ports:
//   a, b  in  [3:0]  addends
//   cin   in         carry-in
//   sum   out [3:0]  a + b + cin (mod 16)
//   cout  out        carry out of bit 3
module kogge_stone_4bit
  import ks_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout
);

  logic [CHUNK_W-1:0] g_s;
  logic [CHUNK_W-1:0] p_s;
  logic [CHUNK_W-1:0] g1_s;
  logic [CHUNK_W-1:0] p1_s;
  logic [CHUNK_W-1:0] g2_s;
  logic [CHUNK_W-1:0] p2_s;
  logic [CHUNK_W:0]   c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Prefix level 1: span 2.
  assign g1_s[0] = g_s[0];
  assign p1_s[0] = p_s[0];
  assign g1_s[1] = g_s[1] | (p_s[1] & g_s[0]);
  assign p1_s[1] = p_s[1] & p_s[0];
  assign g1_s[2] = g_s[2] | (p_s[2] & g_s[1]);
  assign p1_s[2] = p_s[2] & p_s[1];
  assign g1_s[3] = g_s[3] | (p_s[3] & g_s[2]);
  assign p1_s[3] = p_s[3] & p_s[2];

  // Prefix level 2: span 4, giving group (G,P) from bit 0 up to each bit.
  assign g2_s[0] = g1_s[0];
  assign p2_s[0] = p1_s[0];
  assign g2_s[1] = g1_s[1];
  assign p2_s[1] = p1_s[1];
  assign g2_s[2] = g1_s[2] | (p1_s[2] & g1_s[0]);
  assign p2_s[2] = p1_s[2] & p1_s[0];
  assign g2_s[3] = g1_s[3] | (p1_s[3] & g1_s[1]);
  assign p2_s[3] = p1_s[3] & p1_s[1];

  // Carry-in folds in after the prefix tree: c[i+1] = G[i:0] | P[i:0]&cin.
  assign c_s[0] = cin;
  assign c_s[1] = g2_s[0] | (p2_s[0] & cin);
  assign c_s[2] = g2_s[1] | (p2_s[1] & cin);
  assign c_s[3] = g2_s[2] | (p2_s[2] & cin);
  assign c_s[4] = g2_s[3] | (p2_s[3] & cin);

  assign sum  = p_s ^ c_s[CHUNK_W-1:0];
  assign cout = c_s[CHUNK_W];

endmodule

// File: rtl/ks_multiword_add_ctrl.sv
// ks_multiword_add_ctrl: performs W = 4*WORDS bit add/subtract by stepping a
// single 4-bit Kogge-Stone core over the operands, LSB chunk first, with the
// carry registered between chunks.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_a, req_b [W]      operands
//   req_cin               carry-in (ignored when req_sub=1)
//   req_sub               1 = A - B, 0 = A + B
//   rsp_valid/rsp_ready   response handshake
//   rsp_sum [W]           result (held until handshake, kept afterwards)
//   rsp_cout              carry out of MSB (subtract: 1 = no borrow)
//   rsp_ovf               two's-complement overflow
//   busy                  high while an operation is in RUN or DONE
module ks_multiword_add_ctrl
  import ks_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [CHUNK_W*WORDS-1:0]   req_a,
  input  logic [CHUNK_W*WORDS-1:0]   req_b,
  input  logic                       req_cin,
  input  logic                       req_sub,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [CHUNK_W*WORDS-1:0]   rsp_sum,
  output logic                       rsp_cout,
  output logic                       rsp_ovf,
  output logic                       busy
);

  localparam int W     = CHUNK_W * WORDS;
  localparam int CNT_W = clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       a_sh_q, a_sh_d;
  logic [W-1:0]       b_sh_q, b_sh_d;
  // Only the lower WORDS-1 chunks need storing; the top chunk comes straight
  // from the core on the final edge.
  logic [W-CHUNK_W-1:0] sum_sh_q, sum_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       rsp_sum_q, rsp_sum_d;
  logic               rsp_cout_q, rsp_cout_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;

  logic [CHUNK_W-1:0] core_sum_s;
  logic               core_cout_s;
  logic [W-1:0]       sum_cat_s;

  kogge_stone_4bit u_core (
    .a    (a_sh_q[CHUNK_W-1:0]),
    .b    (b_sh_q[CHUNK_W-1:0]),
    .cin  (carry_q),
    .sum  (core_sum_s),
    .cout (core_cout_s)
  );

  // New chunk enters at the top; after the last chunk this is the full result.
  assign sum_cat_s = {core_sum_s, sum_sh_q};

  // Next-state, datapath update and registered-output decode.
  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    sum_sh_d   = sum_sh_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    rsp_ovf_d  = rsp_ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          a_sh_d  = req_a;
          b_sh_d  = req_sub ? ~req_b : req_b;
          carry_d = req_sub ? 1'b1 : req_cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_sh_d = sum_cat_s[W-1:CHUNK_W];
        a_sh_d   = a_sh_q >> CHUNK_W;
        b_sh_d   = b_sh_q >> CHUNK_W;
        carry_d  = core_cout_s;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // a_sh/b_sh bit 3 are the operand MSBs here (b already inverted for sub).
          rsp_sum_d  = sum_cat_s;
          rsp_cout_d = core_cout_s;
          rsp_ovf_d  = a_sh_q[CHUNK_W-1] ^ b_sh_q[CHUNK_W-1]
                     ^ core_sum_s[CHUNK_W-1] ^ core_cout_s;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_ks_multiword_add_ctrl.sv
// tb_ks_multiword_add_ctrl: directed table-driven bench for the multi-word
// add/subtract sequencer (WORDS=4, 16-bit operands), plus hand-written
// backpressure and mid-operation reset sequences.
module tb_ks_multiword_add_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 16;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;
  logic         req_sub;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_ovf;
  logic         busy;

  int errors;
  int checks;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[10];

  ks_multiword_add_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for rsp_valid; returns cycles waited.
  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input int idx);
    int n;
    req_a     = vecs[idx].a;
    req_b     = vecs[idx].b;
    req_cin   = vecs[idx].cin;
    req_sub   = vecs[idx].sub;
    req_valid = 1'b1;
    check($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
    step();  // accept edge
    req_valid = 1'b0;
    check($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
    wait_rsp(n);
    check($sformatf("v%0d latency", idx), 32'(n), 32'(WORDS));
    check($sformatf("v%0d sum", idx), 32'(rsp_sum), 32'(vecs[idx].sum));
    check($sformatf("v%0d cout", idx), 32'(rsp_cout), 32'(vecs[idx].cout));
    check($sformatf("v%0d ovf", idx), 32'(rsp_ovf), 32'(vecs[idx].ovf));
    rsp_ready = 1'b1;
    step();  // response handshake
    rsp_ready = 1'b0;
    check($sformatf("v%0d valid_drop", idx), 32'(rsp_valid), 32'd0);
    check($sformatf("v%0d idle_ready", idx), 32'(req_ready), 32'd1);
  endtask

  initial begin
    int n;
    errors = 0;
    checks = 0;

    //            a         b         cin   sub   sum       cout  ovf
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = 16'h0000;
    req_b     = 16'h0000;
    req_cin   = 1'b0;
    req_sub   = 1'b0;
    rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst rsp_sum", 32'(rsp_sum), 32'd0);
    check("rst rsp_cout", 32'(rsp_cout), 32'd0);
    check("rst rsp_ovf", 32'(rsp_ovf), 32'd0);

    // Idle with no request: nothing starts.
    step();
    check("idle no_start busy", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(i);
    end

    // Backpressure: new request presented during RUN/DONE must be ignored.
    req_a     = 16'h0003;
    req_b     = 16'h0004;
    req_cin   = 1'b0;
    req_sub   = 1'b0;
    req_valid = 1'b1;
    step();  // accept 0x0003 + 0x0004
    req_a = 16'h1111;
    req_b = 16'h1111;
    wait_rsp(n);
    check("bp latency", 32'(n), 32'(WORDS));
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp sum c%0d", k), 32'(rsp_sum), 32'h0007);
      check($sformatf("bp valid c%0d", k), 32'(rsp_valid), 32'd1);
      check($sformatf("bp req_ready c%0d", k), 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();  // handshake
    rsp_ready = 1'b0;
    check("bp post_hs valid", 32'(rsp_valid), 32'd0);
    check("bp post_hs req_ready", 32'(req_ready), 32'd1);
    check("bp post_hs sum_kept", 32'(rsp_sum), 32'h0007);
    step();  // held request accepted now
    req_valid = 1'b0;
    check("bp accept busy", 32'(busy), 32'd1);
    check("bp accept req_ready", 32'(req_ready), 32'd0);
    wait_rsp(n);
    check("bp2 latency", 32'(n), 32'(WORDS));
    check("bp2 sum", 32'(rsp_sum), 32'h2222);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset during the 2nd RUN cycle discards the operation.
    req_a     = 16'h1234;
    req_b     = 16'h1111;
    req_valid = 1'b1;
    step();  // accept; 1st RUN cycle
    req_valid = 1'b0;
    step();  // 2nd RUN cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst req_ready", 32'(req_ready), 32'd1);
    check("mid_rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst rsp_sum", 32'(rsp_sum), 32'd0);
    step();
    step();
    check("mid_rst stays_idle", 32'(busy), 32'd0);

    vecs[0] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    run_op(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
